// File: rtl/palette_fade_ctrl.sv
// 16-entry RGB333 palette with a shadow copy committed on frame start, plus a brightness fade FSM.
// Optional macro PALETTE_FADE_EN enables the fade FSM and scaling; otherwise the level is fixed at 7.
module palette_fade_ctrl #(
    parameter int unsigned RATE_W      = 4,
    parameter int unsigned RESET_LEVEL = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_index,
    output logic [8:0]        o_color,
    input  logic              i_frame_start,
    input  logic              i_wr_valid,
    input  logic [3:0]        i_wr_index,
    input  logic [8:0]        i_wr_color,
    output logic              o_wr_ready,
    input  logic              i_fade_cmd,
    input  logic              i_fade_dir,
    input  logic [RATE_W-1:0] i_fade_rate,
    output logic              o_fade_busy,
    output logic              o_fade_done
);

    function automatic logic [8:0] grey_entry(input logic [3:0] n);
        return {n[3:1], n[3:1], n[3:1]};
    endfunction

    // Subtract (7 - level) from each channel, clamping at zero.
    function automatic logic [8:0] scale(input logic [8:0] c, input logic [2:0] lvl);
        logic [2:0] d;
        logic [2:0] v;
        logic [8:0] r;
        d = 3'd7 - lvl;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            v = c[3*ch +: 3];
            r[3*ch +: 3] = (v > d) ? v - d : 3'd0;
        end
        return r;
    endfunction

    logic [8:0] active_q [16];
    logic [8:0] active_d [16];
    logic [8:0] shadow_q [16];
    logic [8:0] shadow_d [16];
    logic       pending_q, pending_d;
    logic [8:0] color_q, color_d;
    logic [2:0] level;
    logic       commit;
    logic       wr_en;

    assign commit     = i_frame_start && pending_q;
    assign o_wr_ready = !commit;
    assign wr_en      = i_wr_valid && o_wr_ready;

    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (wr_en) begin
            shadow_d[i_wr_index] = i_wr_color;
            pending_d            = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) begin
                active_q[i] <= grey_entry(4'(i));
                shadow_q[i] <= grey_entry(4'(i));
            end
            pending_q <= 1'b0;
            color_q   <= '0;
        end else begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            color_q   <= color_d;
        end
    end

    assign color_d = scale(active_q[i_index], level);
    assign o_color = color_q;

`ifdef PALETTE_FADE_EN
    typedef enum logic {StIdle, StFading} state_e;

    state_e            state_q, state_d;
    logic [2:0]        level_q, level_d;
    logic [2:0]        target_q, target_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [2:0]        cmd_target;
    logic [2:0]        step_level;
    logic              step_now;

    assign cmd_target = i_fade_dir ? 3'd7 : 3'd0;
    // Only meaningful while fading, where level never equals target, so no wrap.
    assign step_level = (target_q > level_q) ? level_q + 3'd1 : level_q - 3'd1;
    // A fade command in the same cycle swallows the frame pulse.
    assign step_now   = (state_q == StFading) && i_frame_start && !i_fade_cmd
                        && (cnt_q == rate_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            level_q  <= 3'(RESET_LEVEL);
            target_q <= '0;
            rate_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            rate_q   <= rate_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_fade_cmd && (level_q != cmd_target)) state_d = StFading;
            end
            StFading: begin
                if (i_fade_cmd) begin
                    state_d = (level_q == cmd_target) ? StIdle : StFading;
                end else if (step_now && (step_level == target_q)) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        level_d  = level_q;
        target_d = target_q;
        rate_d   = rate_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (i_fade_cmd) begin
            target_d = cmd_target;
            rate_d   = i_fade_rate;
            cnt_d    = '0;
            done_d   = (level_q == cmd_target);
        end else if ((state_q == StFading) && i_frame_start) begin
            if (step_now) begin
                level_d = step_level;
                cnt_d   = '0;
                done_d  = (step_level == target_q);
            end else begin
                cnt_d = cnt_q + RATE_W'(1);
            end
        end
    end

    always_comb begin
        o_fade_busy = (state_q == StFading);
        o_fade_done = done_q;
    end

    assign level = level_q;
`else
    logic unused_fade;

    assign unused_fade = ^{i_fade_cmd, i_fade_dir, i_fade_rate, 3'(RESET_LEVEL)};
    assign level       = 3'd7;
    assign o_fade_busy = 1'b0;
    assign o_fade_done = 1'b0;
`endif

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Self-checking bench for palette_fade_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model. Fade expectations follow PALETTE_FADE_EN.
module tb_palette_fade_ctrl;

    localparam int RateW = 4;
`ifdef PALETTE_FADE_EN
    localparam bit FadeEn = 1'b1;
`else
    localparam bit FadeEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       i_index;
    logic [8:0]       o_color;
    logic             i_frame_start;
    logic             i_wr_valid;
    logic [3:0]       i_wr_index;
    logic [8:0]       i_wr_color;
    logic             o_wr_ready;
    logic             i_fade_cmd;
    logic             i_fade_dir;
    logic [RateW-1:0] i_fade_rate;
    logic             o_fade_busy;
    logic             o_fade_done;

    always #5 clk = ~clk;

    palette_fade_ctrl #(
        .RATE_W      (RateW),
        .RESET_LEVEL (7)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_index       (i_index),
        .o_color       (o_color),
        .i_frame_start (i_frame_start),
        .i_wr_valid    (i_wr_valid),
        .i_wr_index    (i_wr_index),
        .i_wr_color    (i_wr_color),
        .o_wr_ready    (o_wr_ready),
        .i_fade_cmd    (i_fade_cmd),
        .i_fade_dir    (i_fade_dir),
        .i_fade_rate   (i_fade_rate),
        .o_fade_busy   (o_fade_busy),
        .o_fade_done   (o_fade_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int act_m[16];
    int sh_m[16];
    bit pend_m;
    int lvl_m, tgt_m, rate_m, cnt_m;
    bit fad_m;
    int exp_color;
    bit exp_done;
    int done_seen;

    function automatic int scale_m(input int c, input int l);
        int r = 0;
        for (int ch = 0; ch < 3; ch++) begin
            int v = (c >> (3 * ch)) % 8;
            int d = 7 - l;
            r += ((v > d) ? v - d : 0) << (3 * ch);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 16; n++) begin
            act_m[n] = (n / 2) * 73;
            sh_m[n]  = (n / 2) * 73;
        end
        pend_m = 0; lvl_m = 7; tgt_m = 0; rate_m = 0; cnt_m = 0; fad_m = 0;
        exp_color = 0; exp_done = 0;
    endtask

    task automatic tick();
        bit rdy;
        @(negedge clk);
        rdy = !(i_frame_start && pend_m);
        check("wr_ready", 32'(o_wr_ready), 32'(rdy));
        @(posedge clk);
        exp_color = scale_m(act_m[i_index], lvl_m);
        exp_done  = 0;
        if (i_frame_start && pend_m) begin
            act_m  = sh_m;
            pend_m = 0;
        end
        if (i_wr_valid && rdy) begin
            sh_m[i_wr_index] = int'(i_wr_color);
            pend_m = 1;
        end
        if (FadeEn) begin
            if (i_fade_cmd) begin
                tgt_m = i_fade_dir ? 7 : 0;
                rate_m = int'(i_fade_rate);
                cnt_m = 0;
                fad_m = (lvl_m != tgt_m);
                exp_done = (lvl_m == tgt_m);
            end else if (fad_m && i_frame_start) begin
                if (cnt_m == rate_m) begin
                    lvl_m += (tgt_m > lvl_m) ? 1 : -1;
                    cnt_m = 0;
                    if (lvl_m == tgt_m) begin
                        fad_m = 0;
                        exp_done = 1;
                    end
                end else begin
                    cnt_m++;
                end
            end
        end
        #1;
        check("color", 32'(o_color), 32'(exp_color));
        check("busy", 32'(o_fade_busy), 32'(fad_m));
        check("done", 32'(o_fade_done), 32'(exp_done));
        if (o_fade_done) done_seen++;
    endtask

    task automatic pulse(input int n);
        for (int k = 0; k < n; k++) begin
            i_frame_start = 1'b1; tick();
            i_frame_start = 1'b0; tick(); tick();
        end
    endtask

    task automatic fade_cmd(input bit dir, input int rate);
        i_fade_cmd = 1'b1; i_fade_dir = dir; i_fade_rate = RateW'(rate);
        tick();
        i_fade_cmd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        i_index = '0; i_frame_start = 1'b0; i_wr_valid = 1'b0; i_wr_index = '0;
        i_wr_color = '0; i_fade_cmd = 1'b0; i_fade_dir = 1'b0; i_fade_rate = '0;
        model_reset();
        #12;
        check("rst_color", 32'(o_color), 32'h0);
        check("rst_ready", 32'(o_wr_ready), 32'h1);
        check("rst_busy", 32'(o_fade_busy), 32'h0);
        check("rst_done", 32'(o_fade_done), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // Grey ramp sweep
        for (int n = 0; n < 16; n++) begin
            i_index = 4'(n);
            tick();
            if (n == 0)  check("grey0", 32'(o_color), 32'h000);
            if (n == 4)  check("grey4", 32'(o_color), 32'h092);
            if (n == 15) check("grey15", 32'(o_color), 32'h1FF);
        end

        // Shadow write is invisible until the frame pulse commits it
        i_wr_valid = 1'b1; i_wr_index = 4'd3; i_wr_color = 9'h1C0; tick();
        i_wr_valid = 1'b0; i_index = 4'd3; tick(); tick();
        check("pre_commit3", 32'(o_color), 32'h049);
        i_frame_start = 1'b1; tick();
        i_frame_start = 1'b0; tick();
        check("post_commit3", 32'(o_color), 32'h1C0);

        // Write colliding with a commit is refused and must be held
        i_wr_valid = 1'b1; i_wr_index = 4'd5; i_wr_color = 9'h038; tick();
        i_wr_index = 4'd6; i_wr_color = 9'h007; i_frame_start = 1'b1;
        #1 check("ready_collide", 32'(o_wr_ready), 32'h0);
        tick();
        i_frame_start = 1'b0; tick();
        i_wr_valid = 1'b0; i_index = 4'd6; tick(); tick();
        check("held_not_live", 32'(o_color), 32'h0DB);
        i_frame_start = 1'b1; tick();
        i_frame_start = 1'b0; tick();
        check("held_committed", 32'(o_color), 32'h007);
        i_index = 4'd5; tick();
        check("collide_commit5", 32'(o_color), 32'h038);

        // Fade out, rate 0
        i_index = 4'd15; done_seen = 0;
        fade_cmd(1'b0, 0);
        check("fade_out_busy", 32'(o_fade_busy), 32'(FadeEn));
        pulse(4);
        check("fade_out_l3", 32'(o_color), FadeEn ? 32'h0DB : 32'h1FF);
        pulse(3);
        check("fade_out_l0", 32'(o_color), FadeEn ? 32'h000 : 32'h1FF);
        pulse(3);
        check("fade_out_dones", 32'(done_seen), 32'(FadeEn));
        check("fade_out_idle", 32'(o_fade_busy), 32'h0);

        // Fade in at rate 1, retargeted to fade out at level 4
        done_seen = 0;
        fade_cmd(1'b1, 1);
        pulse(8);
        check("fade_in_l4", 32'(o_color), FadeEn ? 32'h124 : 32'h1FF);
        fade_cmd(1'b0, 0);
        check("retarget_nodone", 32'(done_seen), 32'h0);
        pulse(4);
        check("retarget_l0", 32'(o_color), FadeEn ? 32'h000 : 32'h1FF);
        check("retarget_dones", 32'(done_seen), 32'(FadeEn));

        // Full fade in at rate 1
        done_seen = 0;
        fade_cmd(1'b1, 1);
        pulse(13);
        check("fade_in_l6", 32'(o_color), FadeEn ? 32'h1B6 : 32'h1FF);
        pulse(1);
        check("fade_in_l7", 32'(o_color), 32'h1FF);
        check("fade_in_dones", 32'(done_seen), 32'(FadeEn));
        done_seen = 0;
        fade_cmd(1'b1, 3);
        tick();
        check("at_target_done", 32'(done_seen), 32'(FadeEn));

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            i_index       = 4'($urandom_range(0, 15));
            i_frame_start = ($urandom_range(0, 7) == 0);
            i_wr_valid    = ($urandom_range(0, 2) == 0);
            i_wr_index    = 4'($urandom_range(0, 15));
            i_wr_color    = 9'($urandom_range(0, 511));
            i_fade_cmd    = ($urandom_range(0, 29) == 0);
            i_fade_dir    = 1'($urandom_range(0, 1));
            i_fade_rate   = RateW'($urandom_range(0, 2));
            tick();
        end

        // Asynchronous reset mid-activity with a pending write
        i_fade_cmd = 1'b0; i_frame_start = 1'b0;
        i_wr_valid = 1'b1; i_wr_index = 4'd15; i_wr_color = 9'h000; tick();
        i_wr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_color", 32'(o_color), 32'h0);
        check("mid_rst_busy", 32'(o_fade_busy), 32'h0);
        check("mid_rst_ready", 32'(o_wr_ready), 32'h1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        i_frame_start = 1'b1; i_index = 4'd15; tick();
        i_frame_start = 1'b0; tick();
        check("rst_dropped_pending", 32'(o_color), 32'h1FF);
        for (int n = 0; n < 16; n++) begin
            i_index = 4'(n);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
